// File: rtl/stream_arbiter_pkg.sv
// Shared types and defaults for the stream arbiter.
package stream_arbiter_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ID_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Requester identifier, also the round-robin "last granted" pointer.
  typedef logic req_id_t;

endpackage

// File: rtl/stream_arbiter_id_fifo.sv
// Return-route FIFO: remembers which requester owns each outstanding packet.
module id_fifo
  import stream_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_ID_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Status flags come straight from the registered count.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/stream_arbiter.sv
// Two-requester packet arbiter in front of a shared core, with response routing.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ID_DEPTH = DEF_ID_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tkeep,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tkeep,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] c_tx_tdata,
  output logic              c_tx_tkeep,
  output logic              c_tx_tvalid,
  output logic              c_tx_tlast,
  input  logic              c_tx_tready,
  input  logic [DATA_W-1:0] c_rx_tdata,
  input  logic              c_rx_tkeep,
  input  logic              c_rx_tvalid,
  input  logic              c_rx_tlast,
  output logic              c_rx_tready,
  output logic [DATA_W-1:0] m0_axis_tdata,
  output logic              m0_axis_tkeep,
  output logic              m0_axis_tvalid,
  output logic              m0_axis_tlast,
  input  logic              m0_axis_tready,
  output logic [DATA_W-1:0] m1_axis_tdata,
  output logic              m1_axis_tkeep,
  output logic              m1_axis_tvalid,
  output logic              m1_axis_tlast,
  input  logic              m1_axis_tready
);

  localparam int unsigned CW = $clog2(ID_DEPTH) + 1;

  state_t          state, state_next;
  req_id_t         rr_ptr, rr_ptr_next;
  logic            fifo_push;
  req_id_t         fifo_push_id;
  logic            fifo_pop;
  req_id_t         fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            count_unused;

  // The count is exposed by the FIFO for observation; the flags drive the logic.
  assign count_unused = ^fifo_count;

  id_fifo #(.DEPTH(ID_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (fifo_push_id),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Grant state and round-robin pointer; pointer=1 lets s0 win the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b1;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Grant decision and request-side mux; handshakes are forced low during reset.
  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    fifo_push      = 1'b0;
    fifo_push_id   = 1'b0;
    c_tx_tdata     = '0;
    c_tx_tkeep     = 1'b0;
    c_tx_tvalid    = 1'b0;
    c_tx_tlast     = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full) begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || rr_ptr)) begin
            state_next   = GRANT0;
            fifo_push    = 1'b1;
            fifo_push_id = 1'b0;
          end else if (s1_axis_tvalid) begin
            state_next   = GRANT1;
            fifo_push    = 1'b1;
            fifo_push_id = 1'b1;
          end
        end
      end
      GRANT0: begin
        c_tx_tdata     = s0_axis_tdata;
        c_tx_tkeep     = s0_axis_tkeep;
        c_tx_tvalid    = s0_axis_tvalid;
        c_tx_tlast     = s0_axis_tlast;
        s0_axis_tready = c_tx_tready;
        if (s0_axis_tvalid && c_tx_tready && s0_axis_tlast) begin
          state_next  = IDLE;
          rr_ptr_next = 1'b0;
        end
      end
      GRANT1: begin
        c_tx_tdata     = s1_axis_tdata;
        c_tx_tkeep     = s1_axis_tkeep;
        c_tx_tvalid    = s1_axis_tvalid;
        c_tx_tlast     = s1_axis_tlast;
        s1_axis_tready = c_tx_tready;
        if (s1_axis_tvalid && c_tx_tready && s1_axis_tlast) begin
          state_next  = IDLE;
          rr_ptr_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      c_tx_tvalid    = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      fifo_push      = 1'b0;
    end
  end

  // Response routing to the requester at the FIFO head; pop on the last beat.
  always_comb begin
    m0_axis_tdata  = c_rx_tdata;
    m0_axis_tkeep  = c_rx_tkeep;
    m0_axis_tlast  = c_rx_tlast;
    m0_axis_tvalid = 1'b0;
    m1_axis_tdata  = c_rx_tdata;
    m1_axis_tkeep  = c_rx_tkeep;
    m1_axis_tlast  = c_rx_tlast;
    m1_axis_tvalid = 1'b0;
    c_rx_tready    = 1'b0;
    fifo_pop       = 1'b0;
    if (!fifo_empty && reset) begin
      if (fifo_head == 1'b0) begin
        m0_axis_tvalid = c_rx_tvalid;
        c_rx_tready    = m0_axis_tready;
      end else begin
        m1_axis_tvalid = c_rx_tvalid;
        c_rx_tready    = m1_axis_tready;
      end
      fifo_pop = c_rx_tvalid & c_rx_tready & c_rx_tlast;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed self-checking bench for stream_arbiter.
module tb_stream_arbiter;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, c_tx_tdata, c_rx_tdata;
  logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
  logic s0_axis_tkeep, s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic s1_axis_tkeep, s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic c_tx_tkeep, c_tx_tvalid, c_tx_tlast, c_tx_tready;
  logic c_rx_tkeep, c_rx_tvalid, c_rx_tlast, c_rx_tready;
  logic m0_axis_tkeep, m0_axis_tvalid, m0_axis_tlast, m0_axis_tready;
  logic m1_axis_tkeep, m1_axis_tvalid, m1_axis_tlast, m1_axis_tready;

  int n_checks = 0;
  int n_fail   = 0;

  stream_arbiter #(.DATA_W(DW), .ID_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .c_tx_tdata(c_tx_tdata), .c_tx_tkeep(c_tx_tkeep), .c_tx_tvalid(c_tx_tvalid),
    .c_tx_tlast(c_tx_tlast), .c_tx_tready(c_tx_tready),
    .c_rx_tdata(c_rx_tdata), .c_rx_tkeep(c_rx_tkeep), .c_rx_tvalid(c_rx_tvalid),
    .c_rx_tlast(c_rx_tlast), .c_rx_tready(c_rx_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tkeep(m0_axis_tkeep),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tlast(m0_axis_tlast),
    .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tkeep(m1_axis_tkeep),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tlast(m1_axis_tlast),
    .m1_axis_tready(m1_axis_tready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    s0_axis_tdata = '0; s0_axis_tkeep = 1'b1; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    s1_axis_tdata = '0; s1_axis_tkeep = 1'b1; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    c_rx_tdata = '0; c_rx_tkeep = 1'b1; c_rx_tvalid = 1'b0; c_rx_tlast = 1'b0;
    c_tx_tready = 1'b1; m0_axis_tready = 1'b1; m1_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; c_rx_tvalid = 1'b1;
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({s0_axis_tready, s1_axis_tready, c_tx_tvalid, c_rx_tready, m0_axis_tvalid, m1_axis_tvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b want 000000",
        {s0_axis_tready, s1_axis_tready, c_tx_tvalid, c_rx_tready, m0_axis_tvalid, m1_axis_tvalid});
    end
    n_checks++;
    if (dut.u_fifo.count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count);
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_packet();
    idle_inputs();
    do_reset();
    s0_axis_tdata = 8'h11; s0_axis_tvalid = 1'b1;
    #1;
    n_checks++;
    if ({c_tx_tvalid, s0_axis_tready} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle_latency: got %b want 00", {c_tx_tvalid, s0_axis_tready});
    end
    tick();
    n_checks++;
    if ({c_tx_tvalid, s0_axis_tready, c_tx_tdata, c_tx_tkeep} !== {2'b11, 8'h11, 1'b1}) begin
      n_fail++; $display("FAIL single_beat0: got v=%b r=%b d=%h k=%b want v=1 r=1 d=11 k=1",
        c_tx_tvalid, s0_axis_tready, c_tx_tdata, c_tx_tkeep);
    end
    n_checks++;
    if (dut.u_fifo.count !== 3'd1) begin
      n_fail++; $display("FAIL single_push_count: got %0d want 1", dut.u_fifo.count);
    end
    s0_axis_tdata = 8'h22; s0_axis_tkeep = 1'b0;
    tick();
    n_checks++;
    if ({c_tx_tvalid, c_tx_tdata, c_tx_tkeep, c_tx_tlast} !== {1'b1, 8'h22, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_beat1: got v=%b d=%h k=%b l=%b want v=1 d=22 k=0 l=0",
        c_tx_tvalid, c_tx_tdata, c_tx_tkeep, c_tx_tlast);
    end
    s0_axis_tdata = 8'h33; s0_axis_tkeep = 1'b1; s0_axis_tlast = 1'b1;
    #1;
    n_checks++;
    if ({c_tx_tvalid, c_tx_tdata, c_tx_tlast} !== {1'b1, 8'h33, 1'b1}) begin
      n_fail++; $display("FAIL single_beat2: got v=%b d=%h l=%b want v=1 d=33 l=1",
        c_tx_tvalid, c_tx_tdata, c_tx_tlast);
    end
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    c_rx_tdata = 8'hA1; c_rx_tvalid = 1'b1;
    #1;
    n_checks++;
    if ({c_tx_tvalid, m0_axis_tvalid, m1_axis_tvalid, c_rx_tready, m0_axis_tdata} !== {4'b0101, 8'hA1}) begin
      n_fail++; $display("FAIL single_echo_route: got txv=%b m0v=%b m1v=%b rxr=%b d=%h want 0 1 0 1 a1",
        c_tx_tvalid, m0_axis_tvalid, m1_axis_tvalid, c_rx_tready, m0_axis_tdata);
    end
    tick();
    c_rx_tdata = 8'hA2; c_rx_tlast = 1'b1;
    tick();
    c_rx_tvalid = 1'b0; c_rx_tlast = 1'b0;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, c_rx_tready} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL single_drain: got count=%0d rxr=%b want 0 0", dut.u_fifo.count, c_rx_tready);
    end
  endtask

  task automatic test_tie_round_robin();
    idle_inputs();
    s0_axis_tdata = 8'hA0; s0_axis_tvalid = 1'b1;
    s1_axis_tdata = 8'hB0; s1_axis_tvalid = 1'b1;
    do_reset();
    #1;
    n_checks++;
    if (c_tx_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL tie_idle: got c_tx_tvalid=%b want 0", c_tx_tvalid);
    end
    tick();
    n_checks++;
    if ({c_tx_tdata, s0_axis_tready, s1_axis_tready} !== {8'hA0, 2'b10}) begin
      n_fail++; $display("FAIL tie_first_s0: got d=%h r0=%b r1=%b want a0 1 0",
        c_tx_tdata, s0_axis_tready, s1_axis_tready);
    end
    s0_axis_tdata = 8'hA1; s0_axis_tlast = 1'b1;
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    #1;
    n_checks++;
    if (c_tx_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL tie_gap: got c_tx_tvalid=%b want 0", c_tx_tvalid);
    end
    tick();
    n_checks++;
    if ({c_tx_tdata, s0_axis_tready, s1_axis_tready} !== {8'hB0, 2'b01}) begin
      n_fail++; $display("FAIL tie_then_s1: got d=%h r0=%b r1=%b want b0 0 1",
        c_tx_tdata, s0_axis_tready, s1_axis_tready);
    end
    s1_axis_tdata = 8'hB1; s1_axis_tlast = 1'b1;
    tick();
    s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    c_rx_tvalid = 1'b1; c_rx_tlast = 1'b1; c_rx_tdata = 8'h5A;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid} !== {3'd2, 2'b10}) begin
      n_fail++; $display("FAIL tie_route_head0: got count=%0d m0v=%b m1v=%b want 2 1 0",
        dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid);
    end
    tick();
    n_checks++;
    if ({m0_axis_tvalid, m1_axis_tvalid} !== 2'b01) begin
      n_fail++; $display("FAIL tie_route_head1: got m0v=%b m1v=%b want 0 1", m0_axis_tvalid, m1_axis_tvalid);
    end
    tick();
    c_rx_tvalid = 1'b0; c_rx_tlast = 1'b0;
  endtask

  task automatic test_fifo_full();
    idle_inputs();
    m0_axis_tready = 1'b0;
    c_rx_tvalid = 1'b1; c_rx_tlast = 1'b1; c_rx_tdata = 8'hC0;
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1; s0_axis_tdata = 8'h40;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (c_tx_tvalid !== 1'b0) begin
        n_fail++; $display("FAIL full_fill_idle%0d: got c_tx_tvalid=%b want 0", k, c_tx_tvalid);
      end
      tick();
      n_checks++;
      if ({c_tx_tvalid, c_rx_tready} !== 2'b10) begin
        n_fail++; $display("FAIL full_fill_grant%0d: got txv=%b rxr=%b want 1 0", k, c_tx_tvalid, c_rx_tready);
      end
      tick();
    end
    #1;
    n_checks++;
    if ({dut.u_fifo.count, c_tx_tvalid, s0_axis_tready} !== {3'd4, 2'b00}) begin
      n_fail++; $display("FAIL full_blocked: got count=%0d txv=%b r0=%b want 4 0 0",
        dut.u_fifo.count, c_tx_tvalid, s0_axis_tready);
    end
    tick();
    n_checks++;
    if ({c_tx_tvalid, s0_axis_tready} !== 2'b00) begin
      n_fail++; $display("FAIL full_still_blocked: got txv=%b r0=%b want 0 0", c_tx_tvalid, s0_axis_tready);
    end
    m0_axis_tready = 1'b1;
    #1;
    n_checks++;
    if ({c_rx_tready, c_tx_tvalid} !== 2'b10) begin
      n_fail++; $display("FAIL full_pop_cycle: got rxr=%b txv=%b want 1 0", c_rx_tready, c_tx_tvalid);
    end
    tick();
    m0_axis_tready = 1'b0;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, c_tx_tvalid} !== {3'd3, 1'b0}) begin
      n_fail++; $display("FAIL full_pop_no_same_cycle_grant: got count=%0d txv=%b want 3 0",
        dut.u_fifo.count, c_tx_tvalid);
    end
    tick();
    n_checks++;
    if ({dut.u_fifo.count, c_tx_tvalid, s0_axis_tready} !== {3'd4, 2'b11}) begin
      n_fail++; $display("FAIL full_regrant: got count=%0d txv=%b r0=%b want 4 1 1",
        dut.u_fifo.count, c_tx_tvalid, s0_axis_tready);
    end
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    m0_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (dut.u_fifo.count !== 3'd0) begin
      n_fail++; $display("FAIL full_drain: got count=%0d want 0", dut.u_fifo.count);
    end
    c_rx_tvalid = 1'b0; c_rx_tlast = 1'b0;
  endtask

  task automatic test_push_pop_same_cycle();
    idle_inputs();
    do_reset();
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1;
    tick(); tick();
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b1; s1_axis_tlast = 1'b1;
    tick(); tick();
    s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    s0_axis_tvalid = 1'b1;
    c_rx_tvalid = 1'b1; c_rx_tlast = 1'b1;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid} !== {3'd2, 2'b10}) begin
      n_fail++; $display("FAIL pp_before: got count=%0d m0v=%b m1v=%b want 2 1 0",
        dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid);
    end
    tick();
    n_checks++;
    if ({dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid, c_tx_tvalid} !== {3'd2, 3'b011}) begin
      n_fail++; $display("FAIL pp_coincide: got count=%0d m0v=%b m1v=%b txv=%b want 2 0 1 1",
        dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid, c_tx_tvalid);
    end
    tick();
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid} !== {3'd1, 2'b10}) begin
      n_fail++; $display("FAIL pp_new_head: got count=%0d m0v=%b m1v=%b want 1 1 0",
        dut.u_fifo.count, m0_axis_tvalid, m1_axis_tvalid);
    end
    tick();
    c_rx_tvalid = 1'b0; c_rx_tlast = 1'b0;
    #1;
    n_checks++;
    if (dut.u_fifo.count !== 3'd0) begin
      n_fail++; $display("FAIL pp_drain: got count=%0d want 0", dut.u_fifo.count);
    end
  endtask

  task automatic test_reset_mid_packet();
    idle_inputs();
    do_reset();
    s1_axis_tvalid = 1'b1; s1_axis_tdata = 8'h61;
    tick();
    c_rx_tvalid = 1'b1;
    #1;
    n_checks++;
    if ({c_tx_tdata, s1_axis_tready, m1_axis_tvalid} !== {8'h61, 2'b11}) begin
      n_fail++; $display("FAIL mid_beat1: got d=%h r1=%b m1v=%b want 61 1 1",
        c_tx_tdata, s1_axis_tready, m1_axis_tvalid);
    end
    tick();
    s1_axis_tdata = 8'h62;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({c_tx_tvalid, s1_axis_tready, c_rx_tready, m1_axis_tvalid} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_during_reset: got txv=%b r1=%b rxr=%b m1v=%b want 0000",
        c_tx_tvalid, s1_axis_tready, c_rx_tready, m1_axis_tvalid);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dut.u_fifo.count, c_tx_tvalid, s0_axis_tready, s1_axis_tready, c_rx_tready,
         m0_axis_tvalid, m1_axis_tvalid} !== {3'd0, 6'b0}) begin
      n_fail++; $display("FAIL mid_after_reset: got count=%0d txv=%b r0=%b r1=%b rxr=%b m0v=%b m1v=%b want 0 all zero",
        dut.u_fifo.count, c_tx_tvalid, s0_axis_tready, s1_axis_tready, c_rx_tready,
        m0_axis_tvalid, m1_axis_tvalid);
    end
    c_rx_tvalid = 1'b0;
    s0_axis_tvalid = 1'b1; s0_axis_tdata = 8'h70; s0_axis_tlast = 1'b1;
    s1_axis_tdata = 8'h63;
    tick();
    n_checks++;
    if ({c_tx_tdata, s0_axis_tready, s1_axis_tready} !== {8'h70, 2'b10}) begin
      n_fail++; $display("FAIL mid_tie_s0: got d=%h r0=%b r1=%b want 70 1 0",
        c_tx_tdata, s0_axis_tready, s1_axis_tready);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_packet();
    test_tie_round_robin();
    test_fifo_full();
    test_push_pop_same_cycle();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
